// File: rtl/shared_adder_sched_pkg.sv
// Shared defaults, id-width helper and id type for the shared adder scheduler.
package shared_adder_sched_pkg;

  localparam int DEF_ADDER_WIDTH = 125;
  localparam int DEF_NUM_REQ     = 4;

  // Requester index width; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_ID_W = id_width(DEF_NUM_REQ);

  typedef logic [DEF_ID_W-1:0] id_t;

endpackage

// File: rtl/shared_adder_sched_rr_arbiter.sv
// Round-robin arbiter: grants the first valid requester at or after ptr,
// and moves ptr just past the winner whenever a grant is issued.
module rr_arbiter
  import shared_adder_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_idx
);

  logic [ID_W-1:0] ptr;
  logic            hit;
  logic [ID_W:0]   cand;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    hit     = 1'b0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NUM_REQ)) cand = cand - (ID_W+1)'(NUM_REQ);
      if (en && !hit && req[cand[ID_W-1:0]]) begin
        hit                     = 1'b1;
        gnt[cand[ID_W-1:0]]     = 1'b1;
        gnt_idx                 = cand[ID_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (hit) begin
      ptr <= (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/shared_adder_sched.sv
// Shared two-stage adder: round-robin selects one operand pair per cycle,
// stage 1 captures operands, stage 2 holds the carry-extended sum.
module shared_adder_sched
  import shared_adder_sched_pkg::*;
#(
  parameter int ADDER_WIDTH = DEF_ADDER_WIDTH,
  parameter int NUM_REQ     = DEF_NUM_REQ
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*ADDER_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*ADDER_WIDTH-1:0] req_b,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [id_width(NUM_REQ)-1:0]   rsp_id,
  output logic [ADDER_WIDTH:0]           rsp_sum
);

  localparam int ID_W = id_width(NUM_REQ);

  function automatic logic [ADDER_WIDTH:0] add_carry(input logic [ADDER_WIDTH-1:0] a,
                                                     input logic [ADDER_WIDTH-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  logic                   advance;
  logic                   arb_en;
  logic                   xfer;
  logic [NUM_REQ-1:0]     gnt;
  logic [ID_W-1:0]        gnt_idx;
  logic [ADDER_WIDTH-1:0] a_sel;
  logic [ADDER_WIDTH-1:0] b_sel;

  logic                   vld_p1;
  logic [ADDER_WIDTH-1:0] a_p1;
  logic [ADDER_WIDTH-1:0] b_p1;
  logic [ID_W-1:0]        id_p1;

  logic                   vld_p2;
  logic [ID_W-1:0]        id_p2;
  logic [ADDER_WIDTH:0]   sum_p2;

  // A full, unaccepted output freezes the whole pipe and the arbiter.
  assign advance   = ~vld_p2 | rsp_ready;
  assign arb_en    = advance & ~reset;
  assign xfer      = |gnt;
  assign req_ready = gnt;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req_valid),
    .en      (arb_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        a_sel = req_a[i*ADDER_WIDTH +: ADDER_WIDTH];
        b_sel = req_b[i*ADDER_WIDTH +: ADDER_WIDTH];
      end
    end
  end

  // Stage 1: granted operands and owner id
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1 <= 1'b0;
    end else if (advance) begin
      vld_p1 <= xfer;
    end
  end

  always_ff @(posedge clk) begin
    if (advance && xfer) begin
      a_p1  <= a_sel;
      b_p1  <= b_sel;
      id_p1 <= gnt_idx;
    end
  end

  // Stage 2: sum with carry-out; a bubble only drops the valid
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p2 <= 1'b0;
      id_p2  <= '0;
      sum_p2 <= '0;
    end else if (advance) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        id_p2  <= id_p1;
        sum_p2 <= add_carry(a_p1, b_p1);
      end
    end
  end

  assign rsp_valid = vld_p2;
  assign rsp_id    = id_p2;
  assign rsp_sum   = sum_p2;

endmodule

// File: tb/tb_shared_adder_sched.sv
// Directed plus randomized bench for shared_adder_sched against a
// transaction-level model of arbitration and the two-deep result pipe.
module tb_shared_adder_sched;
  import shared_adder_sched_pkg::*;

  localparam int W = 125;
  localparam int N = 4;

  logic             clk;
  logic             reset;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*W-1:0]   req_a;
  logic [N*W-1:0]   req_b;
  logic             rsp_valid;
  logic             rsp_ready;
  id_t              rsp_id;
  logic [W:0]       rsp_sum;

  shared_adder_sched #(.ADDER_WIDTH(W), .NUM_REQ(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    int         id;
    logic [W:0] sum;
  } item_t;

  logic [W-1:0] a_in [N];
  logic [W-1:0] b_in [N];

  item_t m0, m1;
  int    mptr;
  bit    zero_known;
  int    mgr;
  int    fires;
  int    vectors;
  int    miscompares;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = a_in[i];
      req_b[i*W +: W] = b_in[i];
    end
  endtask

  task automatic model_reset();
    m0.v = 1'b0; m0.id = 0; m0.sum = '0;
    m1.v = 1'b0; m1.id = 0; m1.sum = '0;
    mptr = 0;
    zero_known = 1'b1;
  endtask

  // One clock: check outputs against the model, advance the model, step the clock.
  task automatic cycle();
    int           g;
    bit           adv;
    logic [N-1:0] exp_rdy;
    drive();
    #1;
    vectors++;
    g       = -1;
    exp_rdy = '0;
    adv     = !m1.v || rsp_ready;
    if (!reset && adv) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (mptr + k) % N;
        if (g < 0 && req_valid[j]) g = j;
      end
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", 128'(req_ready), 128'(exp_rdy));
    chk("rsp_valid", 128'(rsp_valid), 128'(m1.v));
    if (m1.v || zero_known) begin
      chk("rsp_id", 128'(rsp_id), 128'(m1.id));
      chk("rsp_sum", 128'(rsp_sum), 128'(m1.sum));
    end
    chk("ptr", 128'(dut.u_arb.ptr), 128'(mptr));
    if (!reset && rsp_valid && rsp_ready) fires++;
    if (reset) begin
      model_reset();
    end else if (adv) begin
      if (m0.v) begin
        m1 = m0;
        zero_known = 1'b0;
      end else begin
        m1.v = 1'b0;
      end
      m0.v = (g >= 0);
      if (g >= 0) begin
        m0.id  = g;
        m0.sum = {1'b0, a_in[g]} + {1'b0, b_in[g]};
        mptr   = (g + 1) % N;
        mgr++;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [W-1:0] rnd_op();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    if ($urandom_range(0, 7) == 0) t = '1;
    return t[W-1:0];
  endfunction

  initial begin
    int           g0, f0;
    item_t        held;
    logic [W:0]   max_sum;
    vectors = 0; miscompares = 0; mgr = 0; fires = 0;
    reset = 1'b1; req_valid = '0; rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) begin a_in[i] = '0; b_in[i] = '0; end
    drive();
    @(posedge clk); @(negedge clk);
    model_reset();
    cycle();
    chk("reset_rsp_valid", 128'(rsp_valid), 128'd0);
    chk("reset_rsp_sum", 128'(rsp_sum), 128'd0);
    reset = 1'b0;

    // Single request
    a_in[0] = W'(1); b_in[0] = W'(2); req_valid = 4'b0001;
    cycle();
    req_valid = '0;
    cycle();
    chk("s1_valid", 128'(rsp_valid), 128'd1);
    chk("s1_id", 128'(rsp_id), 128'd0);
    chk("s1_sum", 128'(rsp_sum), 128'd3);
    cycle();

    // Carry-out on requester 2
    a_in[2] = '1; b_in[2] = '1; req_valid = 4'b0100;
    cycle();
    req_valid = '0;
    cycle();
    max_sum = '1;
    max_sum = max_sum - 1'b1;
    chk("s2_id", 128'(rsp_id), 128'd2);
    chk("s2_carry", 128'(rsp_sum[W]), 128'd1);
    chk("s2_sum", 128'(rsp_sum), 128'(max_sum));
    cycle();

    // Contention from reset: grants rotate 0,1,2,3,0 with no gaps
    reset = 1'b1; cycle(); reset = 1'b0;
    for (int i = 0; i < N; i++) begin a_in[i] = W'(i); b_in[i] = W'(100); end
    req_valid = 4'b1111;
    for (int k = 0; k < 7; k++) begin
      cycle();
      if (k >= 1) begin
        chk("s3_nogap", 128'(rsp_valid), 128'd1);
        chk("s3_order", 128'(rsp_id), 128'((k - 1) % N));
        chk("s3_sum", 128'(rsp_sum), 128'(100 + (k - 1) % N));
      end
    end

    // Backpressure with three requesters pending
    req_valid = '0;
    for (int k = 0; k < 3; k++) cycle();
    g0 = mgr; f0 = fires;
    for (int i = 0; i < N; i++) begin a_in[i] = rnd_op(); b_in[i] = rnd_op(); end
    rsp_ready = 1'b0; req_valid = 4'b1011;
    cycle(); cycle();
    held = m1;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("s4_stall_ready", 128'(req_ready), 128'd0);
      chk("s4_stall_id", 128'(rsp_id), 128'(held.id));
      chk("s4_stall_sum", 128'(rsp_sum), 128'(held.sum));
    end
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) cycle();
    req_valid = '0;
    for (int k = 0; k < 4; k++) cycle();
    chk("s4_no_loss", 128'(fires - f0), 128'(mgr - g0));

    // Reset right after two transfers discards them
    rsp_ready = 1'b0; req_valid = 4'b0011;
    cycle(); cycle();
    req_valid = '0; reset = 1'b1;
    cycle();
    reset = 1'b0; rsp_ready = 1'b1;
    chk("s5_rsp_valid", 128'(rsp_valid), 128'd0);
    chk("s5_ptr", 128'(dut.u_arb.ptr), 128'd0);
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("s5_quiet", 128'(rsp_valid), 128'd0);
    end

    // Pointer wrap 3 -> 0 -> 1
    req_valid = 4'b0100; cycle();
    chk("s6_ptr3", 128'(dut.u_arb.ptr), 128'd3);
    req_valid = 4'b1000; drive(); #1;
    chk("s6_grant3", 128'(req_ready), 128'b1000);
    cycle();
    chk("s6_ptr0", 128'(dut.u_arb.ptr), 128'd0);
    req_valid = 4'b0001; drive(); #1;
    chk("s6_grant0", 128'(req_ready), 128'b0001);
    cycle();
    chk("s6_ptr1", 128'(dut.u_arb.ptr), 128'd1);
    req_valid = '0;
    cycle(); cycle();

    // Randomized traffic with backpressure and occasional reset
    for (int k = 0; k < 400; k++) begin
      req_valid = N'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      reset     = ($urandom_range(0, 59) == 0);
      for (int i = 0; i < N; i++) begin a_in[i] = rnd_op(); b_in[i] = rnd_op(); end
      cycle();
    end
    reset = 1'b0; req_valid = '0; rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/shared_adder_sched.md
SHARED_ADDER_SCHED -- requirements
Module: shared_adder_sched

Interface
REQ-001 The block SHALL have parameter ADDER_WIDTH, default 125: operand width in bits.
REQ-002 The block SHALL have parameter NUM_REQ, default 4: number of requesters, 2..8.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all logic on the rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port req_valid, input, NUM_REQ bits: per-requester operand-pair valid.
REQ-006 The block SHALL have port req_ready, output, NUM_REQ bits: per-requester accept; one-hot or zero.
REQ-007 The block SHALL have port req_a, input, NUM_REQ*ADDER_WIDTH bits: operand A; requester i occupies slice [i*W +: W].
REQ-008 The block SHALL have port req_b, input, NUM_REQ*ADDER_WIDTH bits: operand B, same packing as req_a.
REQ-009 The block SHALL have port rsp_valid, output, 1 bit: result valid.
REQ-010 The block SHALL have port rsp_ready, input, 1 bit: result consumer accept.
REQ-011 The block SHALL have port rsp_id, output, clog2(NUM_REQ) bits: index of the requester owning the result.
REQ-012 The block SHALL have port rsp_sum, output, ADDER_WIDTH+1 bits: unsigned sum including carry-out.

Function
REQ-013 A transfer on requester i SHALL occur in a cycle where req_valid[i] and req_ready[i] are both high.
REQ-014 req_ready SHALL depend combinationally on req_valid, the round-robin pointer and the pipeline advance signal only; it SHALL never depend on req_a or req_b.
REQ-015 Arbitration SHALL be round-robin: grant the lowest index >= ptr with req_valid set, wrapping modulo NUM_REQ.
REQ-016 After a transfer by requester g, ptr SHALL become (g+1) mod NUM_REQ; with no transfer, ptr SHALL hold.
REQ-017 The pipeline SHALL have two stages. Stage 1 registers the operands and id of the granted requester. Stage 2 registers the (ADDER_WIDTH+1)-bit sum a+b and the id.
REQ-018 The outputs rsp_valid, rsp_id and rsp_sum SHALL be driven directly from stage 2.
REQ-019 Latency SHALL be 2 cycles: a transfer at edge N gives rsp_valid at edge N+2 when there is no backpressure.
REQ-020 Advance SHALL equal (not rsp_valid) or rsp_ready. When advance is low, both stages and ptr SHALL hold and req_ready SHALL be all-zero.
REQ-021 If stage 1 is empty, stage 2 SHALL accept a bubble on advance; bubbles SHALL clear rsp_valid.
REQ-022 With continuous req_valid and rsp_ready high, throughput SHALL be one transfer per cycle.
REQ-023 While rsp_valid is high and rsp_ready is low, rsp_id and rsp_sum SHALL remain stable.
REQ-024 Carry-out SHALL appear in rsp_sum[ADDER_WIDTH]. There is no overflow flag; the sum wraps only beyond ADDER_WIDTH+1 bits, which cannot occur.
REQ-025 Requesters that withdraw req_valid before being granted SHALL lose no state; no grant is remembered across cycles.

Reset
REQ-026 While reset is high at a clock edge, the stage-1 and stage-2 valids, ptr, rsp_id and rsp_sum SHALL be cleared to 0.
REQ-027 During reset, req_ready SHALL be all-zero and rsp_valid SHALL be 0.
REQ-028 Reset asserted mid-operation SHALL discard in-flight results without emitting them.
REQ-029 Operand data registers MAY be left unreset.

Structure
REQ-030 A shared package SHALL hold the default ADDER_WIDTH, the default NUM_REQ, the id-width function and the id type.
REQ-031 A sub-module rr_arbiter SHALL hold the following: the request vector, the enable input (advance), the one-hot grant output, the encoded grant index output, and the pointer register.
REQ-032 The adder SHALL be inferred as a single "+" between registered operands, so that synthesis maps it to the carry chain.

Verification
REQ-033 Scenario 1, single request: reset, then req_valid=0001 with a=1, b=2. Required: rsp_valid 2 cycles later with rsp_id=0 and rsp_sum=3.
REQ-034 Scenario 2, carry-out: a=b=2^125-1 on requester 2. Required: rsp_sum=2^126-2 with bit 125 set, and rsp_id=2.
REQ-035 Scenario 3, contention: all four requesters valid continuously, with operands a=i and b=100 for requester i. Required: grant order 0,1,2,3,0; back-to-back sums 100,101,102,103; no gaps.
REQ-036 Scenario 4, backpressure: rsp_ready held low for 5 cycles with 3 requests pending. Required: rsp_* stable, req_ready=0, ptr frozen; results emitted in order afterwards with none lost or duplicated.
REQ-037 Scenario 5, reset mid-flight: reset asserted 1 cycle after two transfers. Required: rsp_valid stays 0 and ptr is 0 on the first post-reset cycle.
REQ-038 Scenario 6, wrap: only requester 3 then only requester 0 valid. Required: ptr goes 3->0->1, and each request is granted in its first cycle.
